// File: rtl/wasm_frame_stack.sv
// Control-frame stack for the WASM core: push/pop, multi-frame pop for br N,
// atomic replace, peek for label lookup, a RETURN unwind to the nearest call
// frame, and sticky overflow/underflow flags.
//
// state | meaning
// IDLE  | accepting commands; one command per cycle
// SCAN  | RETURN unwind, walking down from the top looking for a call frame
module wasm_frame_stack #(
    parameter int         WIDTH     = 15,
    parameter int         DEPTH     = 16,
    parameter logic [1:0] CALL_TYPE = 2'b01,
    localparam int        CW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CW-1:0]    cmd_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic [CW-2:0]    peek_idx,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             left_one,
    output logic             done,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             err_clr
);

    localparam int            AW      = CW - 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_POPN    = 3'd3;
    localparam logic [2:0] OP_REPLACE = 3'd4;
    localparam logic [2:0] OP_RETURN  = 3'd5;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     scan_idx, scan_nxt;
    logic [CW-1:0]     count_nxt;
    logic              done_nxt;
    logic              set_ovf, set_unf;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     peek_pos;
    logic [1:0]        scan_type;
    logic              accept;

    // Index arithmetic is modulo DEPTH: a full stack (count = DEPTH) still
    // maps count-1 onto the last slot.
    assign top_idx    = count[AW-1:0] - AW'(1);
    assign peek_pos   = top_idx - peek_idx;
    assign scan_type  = mem[scan_idx][WIDTH-1:WIDTH-2];

    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign left_one   = (count == ONE);
    assign top_data   = empty ? '0 : mem[top_idx];
    assign peek_valid = ({1'b0, peek_idx} < count);
    assign peek_data  = peek_valid ? mem[peek_pos] : '0;

    // Command decode, RETURN scan sequencing and error detection.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        scan_nxt  = scan_idx;
        done_nxt  = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = count[AW-1:0];
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                set_ovf = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_waddr = count[AW-1:0];
                                count_nxt = count + ONE;
                            end
                        end
                        OP_POP: begin
                            if (empty) set_unf = 1'b1;
                            else       count_nxt = count - ONE;
                        end
                        OP_POPN: begin
                            // All-or-nothing: an over-long pop leaves the stack intact.
                            if (cmd_n > count) set_unf = 1'b1;
                            else               count_nxt = count - cmd_n;
                        end
                        OP_REPLACE: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_waddr = top_idx;
                            end
                        end
                        OP_RETURN: begin
                            if (empty) begin
                                set_unf  = 1'b1;
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = SCAN;
                                scan_nxt  = top_idx;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SCAN: begin
                if (scan_type == CALL_TYPE) begin
                    // Dropping to scan_idx also pops the call frame itself.
                    count_nxt = {1'b0, scan_idx};
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (scan_idx == '0) begin
                    count_nxt = '0;
                    set_unf   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    scan_nxt = scan_idx - AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, done pulse and sticky flags; a new error beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            scan_idx      <= '0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            scan_idx <= scan_nxt;
            done     <= done_nxt;
            if (set_ovf)      err_overflow <= 1'b1;
            else if (err_clr) err_overflow <= 1'b0;
            if (set_unf)      err_underflow <= 1'b1;
            else if (err_clr) err_underflow <= 1'b0;
        end
    end

    // Frame storage; contents survive reset, only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= push_data;
    end

endmodule

// File: tb/tb_wasm_frame_stack.sv
// Bench for wasm_frame_stack: directed scenarios followed by random commands,
// all checked against a queue-based model of the frame stack.
module tb_wasm_frame_stack;

    localparam int         CW   = 5;
    localparam logic [1:0] CALL = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [4:0]  cmd_n = 5'd0;
    logic [14:0] push_data = 15'd0;
    logic [3:0]  peek_idx = 4'd0;
    logic [14:0] top_data, peek_data;
    logic        peek_valid;
    logic [4:0]  count;
    logic        empty, full, left_one, done;
    logic        err_overflow, err_underflow;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] q[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;

    wasm_frame_stack dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_n(cmd_n), .push_data(push_data), .peek_idx(peek_idx),
        .top_data(top_data), .peek_data(peek_data), .peek_valid(peek_valid),
        .count(count), .empty(empty), .full(full), .left_one(left_one), .done(done),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of one non-RETURN command issued in IDLE.
    task automatic model_apply(input logic [2:0] op, input int n, input logic [14:0] d, input bit clr);
        bit new_ovf = 0;
        bit new_unf = 0;
        case (op)
            3'd1: if (q.size() == 16) new_ovf = 1; else q.push_back(d);
            3'd2: if (q.size() == 0) new_unf = 1; else void'(q.pop_back());
            3'd3: if (n > q.size()) new_unf = 1; else repeat (n) void'(q.pop_back());
            3'd4: if (q.size() == 0) new_unf = 1; else q[q.size()-1] = d;
            default: ;
        endcase
        m_ovf = new_ovf | (m_ovf & ~clr);
        m_unf = new_unf | (m_unf & ~clr);
    endtask

    task automatic issue(input logic [2:0] op, input int n, input logic [14:0] d, input bit clr);
        cmd_valid = 1'b1; cmd_op = op; cmd_n = 5'(n); push_data = d; err_clr = clr;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; err_clr = 1'b0;
        model_apply(op, n, d, clr);
    endtask

    task automatic check_state(input string tag);
        int sz = q.size();
        int pi = $urandom_range(0, 15);
        logic [14:0] exp_top  = (sz > 0) ? q[sz-1] : 15'd0;
        logic [14:0] exp_peek = (pi < sz) ? q[sz-1-pi] : 15'd0;
        peek_idx = 4'(pi);
        #1;
        chk({tag, ":count"}, 32'(count), 32'(sz));
        chk({tag, ":top"}, 32'(top_data), 32'(exp_top));
        chk({tag, ":peek_valid"}, 32'(peek_valid), 32'(pi < sz));
        chk({tag, ":peek_data"}, 32'(peek_data), 32'(exp_peek));
        chk({tag, ":flags"}, {28'd0, empty, full, left_one, cmd_ready},
            {28'd0, sz == 0, sz == 16, sz == 1, 1'b1});
        chk({tag, ":err"}, {29'd0, done, err_overflow, err_underflow}, {29'd0, 1'b0, m_ovf, m_unf});
    endtask

    // RETURN: model finds the nearest call frame from the top.
    task automatic do_return(input string tag);
        int sz = q.size();
        int exp_cnt = 0;
        int exp_lo = sz;
        bit found = 0;
        int lo = 0;
        for (int i = sz - 1; i >= 0; i--) begin
            if (q[i][14:13] == CALL) begin
                found = 1; exp_cnt = i; exp_lo = sz - i;
                break;
            end
        end
        cmd_valid = 1'b1; cmd_op = 3'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        while (!cmd_ready && lo < 40) begin
            @(posedge clk); #1;
            lo++;
        end
        while (q.size() > exp_cnt) void'(q.pop_back());
        if (!found) m_unf = 1;
        chk({tag, ":ready_low"}, 32'(lo), 32'(exp_lo));
        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":count"}, 32'(count), 32'(exp_cnt));
        chk({tag, ":unf"}, 32'(err_underflow), 32'(m_unf));
        @(posedge clk); #1;
        chk({tag, ":done_gone"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        peek_idx = 4'd0;
        #1;
        chk({tag, ":count"}, 32'(count), 32'd0);
        chk({tag, ":flags"}, {26'd0, empty, full, left_one, cmd_ready, done, err_overflow},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk({tag, ":unf"}, 32'(err_underflow), 32'd0);
        chk({tag, ":top"}, 32'(top_data), 32'd0);
        chk({tag, ":peek"}, {16'd0, peek_valid, peek_data}, 32'd0);
    endtask

    initial begin
        // Reset values
        #3;
        check_reset("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Three pushes, top and peek
        issue(3'd1, 0, 15'h1001, 0);
        issue(3'd1, 0, 15'h2002, 0);
        issue(3'd1, 0, 15'h3003, 0);
        check_state("push3");
        chk("count3", 32'(count), 32'd3);
        chk("top3", 32'(top_data), 32'h3003);
        peek_idx = 4'd2; #1;
        chk("peek2", 32'(peek_data), 32'h1001);
        peek_idx = 4'd3; #1;
        chk("peek3_valid", 32'(peek_valid), 32'd0);
        chk("peek3_data", 32'(peek_data), 32'd0);

        // Fill, overflow, replace when full
        for (int i = 3; i < 16; i++) issue(3'd1, 0, 15'(16'h0100 + i), 0);
        issue(3'd1, 0, 15'h0bad, 0);
        check_state("overflow");
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        issue(3'd4, 0, 15'h7fff, 0);
        check_state("replace_full");
        chk("replace_top", 32'(top_data), 32'h7fff);

        // POPN cases from count 5
        issue(3'd0, 0, 15'd0, 1);
        issue(3'd3, 11, 15'd0, 0);
        check_state("popn_to5");
        issue(3'd3, 3, 15'd0, 0);
        chk("popn3", 32'(count), 32'd2);
        issue(3'd3, 4, 15'd0, 0);
        check_state("popn4_unf");
        chk("popn4_flag", 32'(err_underflow), 32'd1);
        issue(3'd3, 0, 15'd0, 0);
        check_state("popn0");

        // RETURN finding a call frame two below the top
        issue(3'd3, 2, 15'd0, 1);
        issue(3'd1, 0, 15'h0011, 0);
        issue(3'd1, 0, 15'h2022, 0);
        issue(3'd1, 0, 15'h6033, 0);
        issue(3'd1, 0, 15'h4044, 0);
        check_state("frames4");
        do_return("ret_call");
        check_state("ret_call_after");
        chk("ret_call_top", 32'(top_data), 32'h0011);

        // RETURN without any call frame
        issue(3'd2, 0, 15'd0, 0);
        issue(3'd1, 0, 15'h0001, 0);
        issue(3'd1, 0, 15'h6002, 0);
        issue(3'd1, 0, 15'h4003, 0);
        do_return("ret_nocall");
        check_state("ret_nocall_after");

        // RETURN on empty
        issue(3'd0, 0, 15'd0, 1);
        do_return("ret_empty");
        check_state("ret_empty_after");

        // err_clr colliding with a new underflow
        issue(3'd0, 0, 15'd0, 1);
        check_state("clr");
        issue(3'd2, 0, 15'd0, 1);
        check_state("clr_vs_unf");
        chk("clr_vs_unf_flag", 32'(err_underflow), 32'd1);

        // Random commands
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 11);
            bit clr = ($urandom_range(0, 7) == 0);
            logic [14:0] d = 15'($urandom_range(0, 32767));
            if (r <= 4)       issue(3'd1, 0, d, clr);
            else if (r == 5)  issue(3'd2, 0, d, clr);
            else if (r == 6)  issue(3'd3, $urandom_range(0, q.size() + 2), d, clr);
            else if (r == 7)  issue(3'd4, 0, d, clr);
            else if (r == 8)  do_return("rnd_ret");
            else if (r == 9)  issue(3'd0, 0, d, clr);
            else              issue(3'(6 + (r - 10)), 0, d, clr);
            check_state("rnd");
        end

        // Reset in the middle of a RETURN scan
        issue(3'd0, 0, 15'd0, 1);
        issue(3'd3, q.size(), 15'd0, 0);
        issue(3'd1, 0, 15'h0001, 0);
        issue(3'd1, 0, 15'h6002, 0);
        issue(3'd1, 0, 15'h4003, 0);
        issue(3'd1, 0, 15'h4004, 0);
        cmd_valid = 1'b1; cmd_op = 3'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0;
        @(posedge clk); #1;
        chk("scan_busy", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        check_reset("mid_scan_reset");
        q.delete(); m_ovf = 0; m_unf = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_state("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wasm_frame_stack.md
# wasm_frame_stack

Parametrised control-frame stack for the WASM core, successor to the single push/pop control stack. It holds call/block/loop/if frames and adds multi-frame pop for `br N`, atomic replace, random-depth peek for label lookup, a multi-cycle `return` unwind to the nearest call frame, and sticky overflow/underflow flags. It sits between the decode/control FSM and the operand-stack pointer logic.

## Interface
- WIDTH, 15: frame entry width. The frame type occupies bits [WIDTH-1:WIDTH-2].
- DEPTH, 16: number of entries. Must be a power of 2 and at least 2.
- CALL_TYPE, 2'b01: frame-type code that terminates a RETURN unwind.
- CW: derived, $clog2(DEPTH)+1. Width of all counts and indices.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command. Low only during a RETURN scan.
- cmd_op  in  3  command: 0 NOP, 1 PUSH, 2 POP, 3 POPN, 4 REPLACE, 5 RETURN. Codes 6 and 7 are treated as NOP.
- cmd_n  in  CW  pop count for POPN.
- push_data  in  WIDTH  entry written by PUSH and REPLACE.
- peek_idx  in  CW-1  depth below the top to peek; 0 is the top.
- top_data  out  WIDTH  entry at the top; 0 when empty.
- peek_data  out  WIDTH  entry at position count-1-peek_idx; 0 when not valid.
- peek_valid  out  1  peek_idx < count.
- count  out  CW  number of occupied entries.
- empty, full, left_one  out  1  asserted when count is 0, DEPTH, and 1 respectively.
- done  out  1  one-cycle pulse when a RETURN completes.
- err_overflow, err_underflow  out  1  sticky error flags.
- err_clr  in  1  clears both sticky flags.

## Operation
- A command is accepted when cmd_valid & cmd_ready. Commands that are not accepted have no effect.
- PUSH:
  - Writes mem[count] ← push_data, then count+1.
  - If full: the command is rejected, err_overflow is set, and no state changes.
- POP:
  - count−1.
  - If empty: err_underflow is set and no state changes.
- POPN:
  - count−cmd_n.
  - cmd_n=0 is a no-op.
  - If cmd_n > count: err_underflow is set and no state changes. The pop is all-or-nothing.
- REPLACE:
  - Writes mem[count-1] ← push_data; count is unchanged.
  - Allowed when full.
  - If empty: err_underflow is set and no state changes.
- RETURN uses an FSM with states IDLE and SCAN.
  - If empty: err_underflow is set, done pulses the next cycle, and the FSM stays in IDLE.
  - Otherwise: the FSM enters SCAN with scan_idx ← count-1.
  - Each SCAN cycle examines mem[scan_idx][WIDTH-1:WIDTH-2]:
    - If it equals CALL_TYPE: count ← scan_idx, which also pops the call frame. done is set and the FSM returns to IDLE.
    - Else if scan_idx=0: count ← 0, err_underflow is set, done is set, and the FSM returns to IDLE.
    - Else: scan_idx−1.
- Memory is not reset. Only the pointer, FSM, and flags are reset.
- top_data and peek_* are combinational reads of the current count and memory.
- Sticky flags: err_clr clears both flags. If err_clr coincides with a new error, the new error wins and the flag is set.
- All count arithmetic is CW bits wide. Valid operations never wrap, because every illegal case is rejected.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0, left_one = 0.
  - cmd_ready = 1, done = 0, both error flags = 0.
  - top_data = 0, peek_valid = 0, peek_data = 0, FSM in IDLE.
- PUSH, POP, POPN, and REPLACE take effect at the accepting edge. The new count, top_data, and flags are visible in the following cycle.
- Back-to-back commands can be issued every cycle while in IDLE.
- RETURN with the matching frame d entries below the top (d=0 means the top):
  - cmd_ready is low for d+1 cycles after acceptance.
  - count updates at edge E0+d+1, where E0 is the accepting edge.
  - done is high for exactly the one cycle after that edge, and cmd_ready returns high in that same cycle.
- Error flags are set at the edge that sees the error.
- Asserting rst_n mid-SCAN aborts the unwind: count = 0 and the FSM returns to IDLE immediately.

## Test plan
- Reset, then push 0x1001, 0x2002, 0x3003.
  - count=3 and top_data=0x3003.
  - peek_idx=2 gives 0x1001; peek_idx=3 gives peek_valid=0.
- Fill all 16 entries, then PUSH again.
  - err_overflow=1 and count stays 16.
  - REPLACE with 0x7FFF leaves top_data=0x7FFF and count=16.
- From count=5:
  - POPN 3 gives count=2.
  - POPN 4 gives err_underflow=1 and count=2.
  - POPN 0 leaves count at 2.
- Push block (type 00), call (01), loop (11), if (10); count=4. Then RETURN:
  - cmd_ready is low for 3 cycles.
  - count=1, done pulses once, top is the block frame.
- With no call frame present (3 frames), RETURN:
  - count=0 after 3 scan cycles, err_underflow=1, done pulses.
  - RETURN on an empty stack gives an immediate underflow plus a done pulse.
- Assert rst_n mid-SCAN: all outputs return to their reset values.
- Assert err_clr in the same cycle as a POP on an empty stack: err_underflow stays 1.
